// File: rtl/bram_rr_arbiter.sv
// Round-robin arbiter sharing one BRAM port among NREQ requesters, with locked bursts and ID-tagged reads.
// One bubble per grant; read data one cycle after the beat; the grant is held while the owner stalls.
module bram_rr_arbiter #(
  parameter int NREQ      = 4,
  parameter int ABITS     = 11,
  parameter int DBITS     = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NREQ-1:0]           req_valid_i,
  input  logic [NREQ-1:0]           req_we_i,
  input  logic [NREQ-1:0]           req_last_i,
  input  logic [NREQ*ABITS-1:0]     req_addr_i,
  input  logic [NREQ*DBITS-1:0]     req_wdata_i,
  output logic [NREQ-1:0]           req_ready_o,
  output logic                      rsp_valid_o,
  output logic [$clog2(NREQ)-1:0]   rsp_id_o,
  output logic [DBITS-1:0]          rsp_data_o,
  output logic [ABITS-1:0]          mem_a_o,
  output logic [DBITS-1:0]          mem_d_o,
  output logic                      mem_we_o,
  output logic                      mem_ce_o,
  input  logic [DBITS-1:0]          mem_q_i
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   owner_q, owner_d;
  logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]    beat_cnt_q, beat_cnt_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0]   rsp_id_q, rsp_id_d;

  logic [IDW-1:0]   pick;
  logic             any_valid;
  logic             own_valid, own_we, own_last;
  logic             beat, release_burst;

  assign own_valid = req_valid_i[owner_q];
  assign own_we    = req_we_i[owner_q];
  assign own_last  = req_last_i[owner_q];

  // Reset gates the beat so no access is issued in the reset cycle.
  assign beat          = !rst_i && (state_q == BURST) && own_valid;
  assign release_burst = beat && (own_last || (beat_cnt_q == CW'(MAX_BURST - 1)));

  // Scan from rr_ptr downward in priority so the nearest valid requester wins.
  always_comb begin : rr_search
    int idx;
    idx       = 0;
    pick      = rr_ptr_q;
    any_valid = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req_valid_i[idx]) begin
        pick      = IDW'(idx);
        any_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      beat_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    beat_cnt_d  = beat_cnt_q;
    rsp_valid_d = beat && !own_we;
    rsp_id_d    = beat ? owner_q : rsp_id_q;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          owner_d = pick;
          state_d = BURST;
        end
      end
      BURST: begin
        if (release_burst) begin
          state_d    = IDLE;
          beat_cnt_d = '0;
          rr_ptr_d   = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    if (!rst_i && state_q == BURST) req_ready_o[owner_q] = own_valid;
    mem_ce_o = beat;
    mem_we_o = beat && own_we;
  end

  assign mem_a_o     = req_addr_i[int'(owner_q)*ABITS +: ABITS];
  assign mem_d_o     = req_wdata_i[int'(owner_q)*DBITS +: DBITS];
  assign rsp_valid_o = rsp_valid_q && !rst_i;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = mem_q_i;

endmodule

// File: tb/tb_bram_rr_arbiter.sv
// Bench for bram_rr_arbiter: directed scenarios plus a randomized run against a transaction-level model.
module tb_bram_rr_arbiter;
  localparam int NREQ = 4;
  localparam int ABITS = 11;
  localparam int DBITS = 8;
  localparam int MAXB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0, req_we = '0, req_last = '0;
  logic [NREQ*ABITS-1:0] req_addr = '0;
  logic [NREQ*DBITS-1:0] req_wdata = '0;
  logic [NREQ-1:0] req_ready;
  logic rsp_valid;
  logic [1:0] rsp_id;
  logic [7:0] rsp_data;
  logic [10:0] mem_a;
  logic [7:0] mem_d;
  logic [7:0] mem_q;
  logic mem_we, mem_ce;

  logic [7:0] bram [0:2047];
  logic pre_en = 1'b0;
  logic [10:0] pre_a = '0;
  logic [7:0] pre_d = '0;

  int n_checks = 0;
  int n_fail = 0;

  // Random-run state
  int rem [NREQ];
  logic cwe [NREQ];
  logic [10:0] caddr [NREQ];
  logic [7:0] cdata [NREQ];
  logic [7:0] gold [0:15];

  bram_rr_arbiter #(.NREQ(NREQ), .ABITS(ABITS), .DBITS(DBITS), .MAX_BURST(MAXB)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_we_i(req_we), .req_last_i(req_last),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
    .mem_a_o(mem_a), .mem_d_o(mem_d), .mem_we_o(mem_we), .mem_ce_o(mem_ce),
    .mem_q_i(mem_q)
  );

  always #5 clk = ~clk;

  // Macro model: synchronous write, registered read.
  always @(posedge clk) begin
    if (pre_en) bram[pre_a] <= pre_d;
    else if (mem_ce) begin
      if (mem_we) bram[mem_a] <= mem_d;
      else mem_q <= bram[mem_a];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic clear_req;
    req_valid = '0; req_we = '0; req_last = '0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [10:0] a, input logic [7:0] d, input logic last);
    req_valid[i] = 1'b1;
    req_we[i] = we;
    req_last[i] = last;
    req_addr[i*ABITS +: ABITS] = a;
    req_wdata[i*DBITS +: DBITS] = d;
  endtask

  task automatic preload(input logic [10:0] a, input logic [7:0] d);
    pre_en = 1'b1; pre_a = a; pre_d = d;
    tick;
    pre_en = 1'b0;
  endtask

  task automatic do_reset;
    clear_req;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    clear_req;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    settle;
    n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_ready got=%0h exp=0", req_ready); end
    n_checks++; if (mem_ce !== 1'b0) begin n_fail++; $display("FAIL reset_mem_ce got=%0b exp=0", mem_ce); end
    n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL reset_mem_we got=%0b exp=0", mem_we); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL reset_rsp_id got=%0d exp=0", rsp_id); end
    set_req(2, 1'b0, 11'd0, 8'd0, 1'b1);
    settle;
    n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL reset_bubble got=%0h exp=0", req_ready); end
    tick;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL reset_first_grant got=%0h exp=4", req_ready); end
    do_reset;
  endtask

  task automatic test_single_read;
    preload(11'h7FF, 8'hA5);
    do_reset;
    set_req(0, 1'b0, 11'h7FF, 8'h00, 1'b1);
    settle;
    n_checks++; if (req_ready !== 4'h0) begin n_fail++; $display("FAIL single_bubble got=%0h exp=0", req_ready); end
    tick;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL single_grant got=%0h exp=1", req_ready); end
    n_checks++; if (mem_ce !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL single_ce_we got=%0b%0b exp=10", mem_ce, mem_we); end
    n_checks++; if (mem_a !== 11'h7FF) begin n_fail++; $display("FAIL single_addr got=%0h exp=7ff", mem_a); end
    tick;
    clear_req;
    settle;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid got=%0b exp=1", rsp_valid); end
    n_checks++; if (rsp_id !== 2'd0) begin n_fail++; $display("FAIL single_rsp_id got=%0d exp=0", rsp_id); end
    n_checks++; if (rsp_data !== 8'hA5) begin n_fail++; $display("FAIL single_rsp_data got=%0h exp=a5", rsp_data); end
    tick;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_once got=%0b exp=0", rsp_valid); end
  endtask

  task automatic test_contention;
    logic [3:0] exp_r, served;
    do_reset;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 11'(i), 8'(i), 1'b1);
    for (int c = 0; c <= 8; c++) begin
      settle;
      exp_r = (c % 2 == 1 && c < 8) ? 4'(1 << (c / 2)) : 4'h0;
      n_checks++; if (req_ready !== exp_r) begin n_fail++; $display("FAIL contention_ready c=%0d got=%0h exp=%0h", c, req_ready, exp_r); end
      n_checks++; if (mem_ce !== (exp_r != 4'h0)) begin n_fail++; $display("FAIL contention_ce c=%0d got=%0b exp=%0b", c, mem_ce, exp_r != 4'h0); end
      if (exp_r != 4'h0) begin
        n_checks++; if (mem_a !== 11'(c / 2) || mem_d !== 8'(c / 2)) begin n_fail++; $display("FAIL contention_wr c=%0d got=%0h/%0h exp=%0h", c, mem_a, mem_d, c / 2); end
      end
      served = req_ready & req_valid;
      tick;
      req_valid = req_valid & ~served;
    end
    clear_req;
    for (int c = 0; c <= 5; c++) begin
      if (c <= 4) set_req(0, 1'b0, 11'((c == 0) ? 0 : c - 1), 8'h00, c == 4);
      else clear_req;
      settle;
      if (c >= 1 && c <= 4) begin
        n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL readback_ready c=%0d got=%0h exp=1", c, req_ready); end
      end
      if (c >= 2) begin
        n_checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== 8'(c - 2)) begin
          n_fail++; $display("FAIL readback_rsp c=%0d got=%0b/%0d/%0h exp=1/0/%0h", c, rsp_valid, rsp_id, rsp_data, c - 2);
        end
      end
      tick;
    end
  endtask

  task automatic test_burst_lock;
    int k;
    do_reset;
    set_req(2, 1'b0, 11'd0, 8'd0, 1'b1);
    for (int c = 0; c <= 7; c++) begin
      k = (c == 0) ? 0 : c - 1;
      if (c <= 4) set_req(1, 1'b1, 11'(16 + k), 8'(8'h50 + k), c == 4);
      else req_valid[1] = 1'b0;
      if (c >= 7) req_valid[2] = 1'b0;
      settle;
      n_checks++; if (req_ready[2] !== (c == 6)) begin n_fail++; $display("FAIL lock_req2 c=%0d got=%0b exp=%0b", c, req_ready[2], c == 6); end
      n_checks++; if (req_ready[1] !== (c >= 1 && c <= 4)) begin n_fail++; $display("FAIL lock_req1 c=%0d got=%0b exp=%0b", c, req_ready[1], c >= 1 && c <= 4); end
      tick;
    end
    clear_req;
    tick;
  endtask

  task automatic test_forced_release;
    int b, r0, r3;
    logic done3;
    for (int k = 0; k < 20; k++) preload(11'(k), 8'(k * 7 + 3));
    preload(11'h100, 8'hEE);
    do_reset;
    b = 0; r0 = 0; r3 = 0; done3 = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (b < 20) set_req(0, 1'b0, 11'(b), 8'h00, 1'b0);
      else req_valid[0] = 1'b0;
      if (!done3) set_req(3, 1'b0, 11'h100, 8'h00, 1'b1);
      else req_valid[3] = 1'b0;
      settle;
      n_checks++; if ($countones(req_ready) > 1) begin n_fail++; $display("FAIL forced_onehot c=%0d got=%0h", c, req_ready); end
      if (rsp_valid === 1'b1) begin
        if (rsp_id === 2'd0) begin
          n_checks++; if (rsp_data !== 8'(r0 * 7 + 3)) begin n_fail++; $display("FAIL forced_rsp0 n=%0d got=%0h exp=%0h", r0, rsp_data, 8'(r0 * 7 + 3)); end
          r0++;
        end else begin
          n_checks++; if (rsp_id !== 2'd3 || rsp_data !== 8'hEE) begin n_fail++; $display("FAIL forced_rsp3 got=%0d/%0h exp=3/ee", rsp_id, rsp_data); end
          r3++;
        end
      end
      if (req_ready[0] && req_valid[0]) b++;
      if (req_ready[3] && req_valid[3]) begin
        done3 = 1'b1;
        n_checks++; if (b != 16) begin n_fail++; $display("FAIL forced_release_point got=%0d exp=16", b); end
      end
      tick;
    end
    n_checks++; if (r0 != 20) begin n_fail++; $display("FAIL forced_rsp0_count got=%0d exp=20", r0); end
    n_checks++; if (r3 != 1) begin n_fail++; $display("FAIL forced_rsp3_count got=%0d exp=1", r3); end
  endtask

  task automatic test_stall;
    int k, st, nrsp;
    logic stalling, done1;
    do_reset;
    k = 0; st = 0; nrsp = 0; done1 = 1'b0;
    for (int c = 0; c < 25; c++) begin
      stalling = (k == 3 && st < 5);
      if (k < 6 && !stalling) set_req(0, 1'b1, 11'(32'h200 + k), 8'(8'h90 + k), k == 5);
      else req_valid[0] = 1'b0;
      if (!done1) set_req(1, 1'b0, 11'h200, 8'h00, 1'b1);
      else req_valid[1] = 1'b0;
      settle;
      if (stalling) begin
        n_checks++; if (mem_ce !== 1'b0 || req_ready !== 4'h0) begin n_fail++; $display("FAIL stall_idle st=%0d got=%0b/%0h exp=0/0", st, mem_ce, req_ready); end
        st++;
      end
      if (req_ready[0] && req_valid[0]) begin
        n_checks++; if (mem_we !== 1'b1 || mem_a !== 11'(32'h200 + k) || mem_d !== 8'(8'h90 + k)) begin
          n_fail++; $display("FAIL stall_beat k=%0d got=%0b/%0h/%0h exp=1/%0h/%0h", k, mem_we, mem_a, mem_d, 32'h200 + k, 8'h90 + k);
        end
        k++;
      end
      if (req_ready[1] && req_valid[1]) begin
        done1 = 1'b1;
        n_checks++; if (k != 6) begin n_fail++; $display("FAIL stall_req1_early got=%0d exp=6", k); end
      end
      if (rsp_valid === 1'b1) begin
        n_checks++; if (rsp_id !== 2'd1 || rsp_data !== 8'h90) begin n_fail++; $display("FAIL stall_raw got=%0d/%0h exp=1/90", rsp_id, rsp_data); end
        nrsp++;
      end
      tick;
    end
    n_checks++; if (st != 5 || nrsp != 1) begin n_fail++; $display("FAIL stall_summary got=%0d/%0d exp=5/1", st, nrsp); end
  endtask

  task automatic test_reset_mid_burst;
    do_reset;
    set_req(2, 1'b0, 11'd5, 8'd0, 1'b1);
    settle;
    tick;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL rmb_grant got=%0h exp=4", req_ready); end
    tick;
    set_req(2, 1'b0, 11'd5, 8'd0, 1'b0);
    settle;
    n_checks++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL rmb_first_rsp got=%0b exp=1", rsp_valid); end
    tick;
    n_checks++; if (req_ready !== 4'b0100 || mem_ce !== 1'b1) begin n_fail++; $display("FAIL rmb_regrant got=%0h/%0b exp=4/1", req_ready, mem_ce); end
    tick;
    rst = 1'b1;
    settle;
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rmb_rsp_drop got=%0b exp=0", rsp_valid); end
    n_checks++; if (mem_ce !== 1'b0 || req_ready !== 4'h0) begin n_fail++; $display("FAIL rmb_no_access got=%0b/%0h exp=0/0", mem_ce, req_ready); end
    tick;
    rst = 1'b0;
    clear_req;
    set_req(1, 1'b0, 11'd0, 8'd0, 1'b1);
    set_req(3, 1'b0, 11'd0, 8'd0, 1'b1);
    settle;
    n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'h0) begin n_fail++; $display("FAIL rmb_idle got=%0b/%0h exp=0/0", rsp_valid, req_ready); end
    tick;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL rmb_ptr_reset got=%0h exp=2", req_ready); end
    do_reset;
  endtask

  task automatic new_beat(input int i);
    cwe[i] = 1'($urandom_range(0, 1));
    caddr[i] = 11'($urandom_range(0, 15));
    cdata[i] = 8'($urandom);
  endtask

  task automatic test_random;
    logic granted, exp_rv, drained, beat_m;
    int owner, ptr, cnt, exp_rid, j;
    logic [7:0] exp_rd, v;
    logic [3:0] exp_r;
    do_reset;
    for (int a = 0; a < 16; a++) begin
      v = 8'($urandom);
      gold[a] = v;
      preload(11'(a), v);
    end
    for (int i = 0; i < NREQ; i++) begin rem[i] = 0; new_beat(i); end
    granted = 1'b0; owner = 0; ptr = 0; cnt = 0; exp_rv = 1'b0; exp_rid = 0; exp_rd = '0; drained = 1'b0;
    for (int cyc = 0; cyc < 1600 && !drained; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (cyc < 800 && rem[i] == 0 && $urandom_range(0, 2) == 0) rem[i] = $urandom_range(1, 20);
        if (rem[i] > 0 && (cyc >= 800 || $urandom_range(0, 4) != 0)) set_req(i, cwe[i], caddr[i], cdata[i], rem[i] == 1);
        else req_valid[i] = 1'b0;
      end
      settle;
      exp_r = '0;
      if (granted) exp_r[owner] = req_valid[owner];
      beat_m = granted && req_valid[owner];
      n_checks++; if (req_ready !== exp_r) begin n_fail++; $display("FAIL rand_ready cyc=%0d got=%0h exp=%0h", cyc, req_ready, exp_r); end
      n_checks++; if (mem_ce !== beat_m) begin n_fail++; $display("FAIL rand_ce cyc=%0d got=%0b exp=%0b", cyc, mem_ce, beat_m); end
      if (beat_m) begin
        n_checks++; if (mem_we !== cwe[owner] || mem_a !== caddr[owner] || (cwe[owner] && mem_d !== cdata[owner])) begin
          n_fail++; $display("FAIL rand_beat cyc=%0d got=%0b/%0h/%0h exp=%0b/%0h/%0h", cyc, mem_we, mem_a, mem_d, cwe[owner], caddr[owner], cdata[owner]);
        end
      end
      n_checks++; if (rsp_valid !== exp_rv) begin n_fail++; $display("FAIL rand_rsp_valid cyc=%0d got=%0b exp=%0b", cyc, rsp_valid, exp_rv); end
      if (exp_rv) begin
        n_checks++; if (rsp_id !== 2'(exp_rid) || rsp_data !== exp_rd) begin n_fail++; $display("FAIL rand_rsp cyc=%0d got=%0d/%0h exp=%0d/%0h", cyc, rsp_id, rsp_data, exp_rid, exp_rd); end
      end
      exp_rv = 1'b0;
      if (beat_m) begin
        if (cwe[owner]) gold[caddr[owner][3:0]] = cdata[owner];
        else begin exp_rv = 1'b1; exp_rid = owner; exp_rd = gold[caddr[owner][3:0]]; end
        cnt++;
        rem[owner]--;
        new_beat(owner);
        if (rem[owner] == 0 || cnt == MAXB) begin
          granted = 1'b0; ptr = (owner + 1) % NREQ; cnt = 0;
        end
      end else if (!granted) begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          j = (ptr + k) % NREQ;
          if (req_valid[j]) begin owner = j; granted = 1'b1; end
        end
      end
      drained = (cyc >= 800) && !granted && !exp_rv;
      for (int i = 0; i < NREQ; i++) if (rem[i] != 0) drained = 1'b0;
      tick;
    end
    n_checks++; if (!drained) begin n_fail++; $display("FAIL rand_drain got=busy exp=idle"); end
    clear_req;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single_read;
    test_contention;
    test_burst_lock;
    test_forced_release;
    test_stall;
    test_reset_mid_burst;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
